bist_sig_check: RTL and testbench

BIST_SIG_CHECK -- requirements
Module: bist_sig_check

---
 rtl/bist_pkg.sv | 20 ++
 rtl/bist_cycle_cnt.sv | 32 +++
 rtl/bist_sig_check.sv | 133 +++++++++++++
 tb/tb_bist_sig_check.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared types and constants for the BIST signature checker.
//   state_t    - controller state encoding
//   SIG_W_DEF  - default signature width (matches the MISR output)
//   CLR_CYCLES - number of cycles the MISR clear is held
package bist_pkg;

    localparam int SIG_W_DEF  = 7;
    localparam int CLR_CYCLES = 2;
    localparam int CLR_W      = (CLR_CYCLES < 2) ? 1 : $clog2(CLR_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_CMP    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/bist_cycle_cnt.sv
// bist_cycle_cnt: loadable down-counter with a zero flag; stops at zero.
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset (count cleared to 0)
//   load_i     - load load_val_i (wins over en_i)
//   en_i       - decrement by one when not already zero
//   load_val_i - value loaded on load_i
//   zero_o     - count is zero
module bist_cycle_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign zero_o = (cnt_q == '0);

    always_comb begin
        cnt_d = load_i ? load_val_i : (en_i && !zero_o) ? cnt_q - W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bist_sig_check.sv
// bist_sig_check: sequences a MISR (clear, compact, settle) and compares its signature to GOLDEN.
//   clk         - rising-edge clock
//   reset       - asynchronous active-low reset
//   start       - begin a test (honoured only in IDLE or DONE)
//   abort       - return to IDLE from any state, wins over everything
//   misr_sig    - signature from the MISR
//   misr_reset  - active-high MISR clear
//   misr_enable - active-high MISR compaction enable
//   busy        - test in progress
//   done        - test finished, pass/sig_out valid
//   pass        - captured signature equals GOLDEN
//   sig_out     - captured signature
// Optional macro BIST_SIG_CAPTURE_EN: when defined sig_out holds the captured
// signature; when undefined sig_out is tied to 0 and no capture register exists.
// All outputs are registered decodes of the current state, so they trail the
// state register by one cycle; abort and restart clear them on the same edge
// as the state change.
module bist_sig_check
    import bist_pkg::*;
#(
    parameter int               SIG_W      = SIG_W_DEF,
    parameter int               RUN_CYCLES = 5000,
    parameter logic [SIG_W-1:0] GOLDEN     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             misr_reset,
    output logic             misr_enable,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] sig_out
);

    localparam int CNT_W = (RUN_CYCLES < 1) ? 1 : $clog2(RUN_CYCLES + 1);

    if (RUN_CYCLES < 1) begin : g_bad_run_cycles
        $error("bist_sig_check: RUN_CYCLES must be >= 1");
    end

    state_t           state_q, state_d;
    logic [CLR_W-1:0] clr_q, clr_d;
    logic             misr_reset_q, misr_reset_d;
    logic             misr_enable_q, misr_enable_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             cnt_load, cnt_zero;

    // Counter is loaded with RUN_CYCLES-1 so RUN covers counts RUN_CYCLES-1..0,
    // i.e. exactly RUN_CYCLES cycles, and exits on the zero flag.
    assign cnt_load = (state_q == S_CLR) && (state_d == S_RUN);

    bist_cycle_cnt #(
        .W (CNT_W)
    ) u_run_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .en_i       (state_q == S_RUN),
        .load_val_i (CNT_W'(RUN_CYCLES - 1)),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_CLR;
            S_CLR:          if (clr_q == CLR_W'(CLR_CYCLES - 1)) state_d = S_RUN;
            S_RUN:          if (cnt_zero) state_d = S_SETTLE;
            S_SETTLE:       state_d = S_CMP;
            S_CMP:          state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
        clr_d         = (state_q == S_CLR && state_d == S_CLR) ? clr_q + CLR_W'(1) : '0;
        misr_reset_d  = !abort && (state_q == S_CLR);
        misr_enable_d = !abort && (state_q == S_RUN);
        busy_d        = !abort && !(state_q == S_IDLE || state_q == S_DONE);
        // done drops on the same edge a restart or abort leaves DONE
        done_d        = (state_q == S_DONE) && (state_d == S_DONE);
        pass_d        = abort ? 1'b0 :
                        (state_q == S_CMP) ? (misr_sig == GOLDEN) :
                        (state_d == S_CLR) ? 1'b0 : pass_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            clr_q         <= '0;
            misr_reset_q  <= 1'b0;
            misr_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_q         <= clr_d;
            misr_reset_q  <= misr_reset_d;
            misr_enable_q <= misr_enable_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
        end
    end

    assign misr_reset  = misr_reset_q;
    assign misr_enable = misr_enable_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;

`ifdef BIST_SIG_CAPTURE_EN
    logic [SIG_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = (!abort && state_q == S_CMP) ? misr_sig : sig_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign sig_out = sig_q;
`else
    assign sig_out = '0;
`endif

endmodule

// File: tb/tb_bist_sig_check.sv
// tb_bist_sig_check: directed vector table plus hand-written abort/reset sequences for bist_sig_check.
module tb_bist_sig_check;

    localparam int         RC   = 8;
    localparam logic [6:0] GOLD = 7'h5A;
    localparam int         LAT  = 2 + RC + 1 + 1 + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [6:0] misr_sig = 7'h00;
    logic       misr_reset, misr_enable, busy, done, pass;
    logic [6:0] sig_out;

    int tests = 0;
    int fails = 0;

    bist_sig_check #(
        .SIG_W      (7),
        .RUN_CYCLES (RC),
        .GOLDEN     (GOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .misr_sig    (misr_sig),
        .misr_reset  (misr_reset),
        .misr_enable (misr_enable),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .sig_out     (sig_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] sig;
        int         pulse_at;
        logic       exp_pass;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] cap(input logic [6:0] s);
`ifdef BIST_SIG_CAPTURE_EN
        return s;
`else
        return 7'h00;
`endif
    endfunction

    task automatic run_test(input logic [6:0] s, input int pulse_at,
                            output int lat, output int rc, output int ec, output logic clr_ok);
        misr_sig = s;
        start = 1'b1;
        step();
        start = 1'b0;
        clr_ok = !done && !pass;
        lat = 0;
        rc = 0;
        ec = 0;
        while (!done && lat < 40) begin
            rc += int'(misr_reset);
            ec += int'(misr_enable);
            start = (pulse_at >= 0 && misr_enable && ec == pulse_at);
            step();
            start = 1'b0;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, rc, ec, bad;
        logic clr_ok;
        vecs[0] = '{7'h5A, -1, 1'b1};
        vecs[1] = '{7'h5B, -1, 1'b0};
        vecs[2] = '{7'h00,  3, 1'b0};
        vecs[3] = '{7'h7F, -1, 1'b0};
        vecs[4] = '{7'h5A,  3, 1'b1};

        #100;
        chk("reset_outs", {misr_reset, misr_enable, busy, done, pass, sig_out}, 0);
        #102;
        reset = 1'b1;
        step();
        step();
        chk("idle_after_reset", {misr_reset, misr_enable, busy, done, pass, sig_out}, 0);

        for (int i = 0; i < 5; i++) begin
            run_test(vecs[i].sig, vecs[i].pulse_at, lat, rc, ec, clr_ok);
            chk($sformatf("v%0d_latency", i), lat, LAT);
            chk($sformatf("v%0d_clr_cycles", i), rc, 2);
            chk($sformatf("v%0d_en_cycles", i), ec, RC);
            chk($sformatf("v%0d_restart_clear", i), clr_ok, 1);
            chk($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
            chk($sformatf("v%0d_sig_out", i), sig_out, cap(vecs[i].sig));
            chk($sformatf("v%0d_done_busy", i), {done, busy}, 2'b10);
            if (i == 0) begin
                bad = 0;
                repeat (50) begin
                    step();
                    if (!done || pass !== 1'b1 || sig_out !== cap(7'h5A) || busy) bad++;
                end
                chk("done_hold_50", bad, 0);
            end
        end

        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_beats_start", {done, pass, busy}, 0);
        chk("abort_sig_held", sig_out, cap(7'h5A));
        step();
        step();
        chk("abort_stays_idle", {misr_reset, misr_enable, busy}, 0);

        misr_sig = 7'h5B;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("run4_enable", misr_enable, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_run_outs", {misr_enable, misr_reset, busy, done, pass}, 0);
        chk("abort_run_sig_held", sig_out, cap(7'h5A));
        repeat (20) step();
        chk("abort_no_resume", {misr_enable, misr_reset, busy, done}, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("pre_reset_enable", {misr_enable, busy}, 2'b11);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_outs", {misr_reset, misr_enable, busy, done, pass, sig_out}, 0);
        #20;
        reset = 1'b1;
        repeat (20) step();
        chk("reset_no_resume", {misr_reset, misr_enable, busy, done, pass}, 0);

        run_test(7'h5B, -1, lat, rc, ec, clr_ok);
        chk("post_reset_latency", lat, LAT);
        chk("post_reset_en_cycles", ec, RC);
        chk("post_reset_result", {pass, sig_out}, {1'b0, cap(7'h5B)});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
